// File: rtl/posit_add_pipe_es3.sv
// Three-stage pipelined adder for decoded posit (es=3) operands: compare/swap, align/add, normalize.
// Optional input register stage enabled by defining POSIT_ADD_PIPE_INPUT_REG_EN.
module posit_add_pipe_es3 #(
  parameter int ES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [38:0] in1,
  input  logic [38:0] in2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [41:0] out,
  output logic        truncated,
  output logic        out_valid,
  input  logic        out_ready
);
  localparam int SW = ES + 6;

  logic        adv;
  logic [38:0] op_a, op_b;
  logic        op_valid;

`ifdef POSIT_ADD_PIPE_INPUT_REG_EN
  logic [38:0] in1_q, in1_d, in2_q, in2_d;
  logic        in_valid_q, in_valid_d;

  always_comb begin
    in1_d      = adv ? in1 : in1_q;
    in2_d      = adv ? in2 : in2_q;
    in_valid_d = adv ? in_valid : in_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in1_q      <= '0;
      in2_q      <= '0;
      in_valid_q <= 1'b0;
    end else begin
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      in_valid_q <= in_valid_d;
    end
  end

  assign op_a     = in1_q;
  assign op_b     = in2_q;
  assign op_valid = in_valid_q;
`else
  assign op_a     = in1;
  assign op_b     = in2;
  assign op_valid = in_valid;
`endif

  // Stage registers
  logic          v1_q, v1_d, sgn1_q, sgn1_d, sub1_q, sub1_d, byp1_q, byp1_d;
  logic [SW-1:0] scale1_q, scale1_d;
  logic [26:0]   fl1_q, fl1_d, fs1_q, fs1_d;
  logic [4:0]    sh1_q, sh1_d;
  logic [41:0]   bypv1_q, bypv1_d;
  logic          v2_q, v2_d, sgn2_q, sgn2_d, sticky2_q, sticky2_d, byp2_q, byp2_d;
  logic [SW-1:0] scale2_q, scale2_d;
  logic [31:0]   sum2_q, sum2_d;
  logic [41:0]   bypv2_q, bypv2_d;
  logic          out_valid_q, out_valid_d, truncated_q, truncated_d;
  logic [41:0]   out_q, out_d;

  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv;
  assign out       = out_q;
  assign truncated = truncated_q;
  assign out_valid = out_valid_q;

  // S1: flipping the scale sign bit makes the {scale, fraction} key unsigned-comparable
  logic [35:0] key_a, key_b;
  logic        swap, byp;
  logic [36:0] lg, sm;
  logic [9:0]  diff;
  logic [41:0] byp_val;

  always_comb begin
    key_a   = {~op_a[37], op_a[36:2]};
    key_b   = {~op_b[37], op_b[36:2]};
    swap    = key_b > key_a;
    lg      = swap ? op_b[38:2] : op_a[38:2];
    sm      = swap ? op_a[38:2] : op_b[38:2];
    diff    = {lg[35], lg[35:27]} - {sm[35], sm[35:27]};
    byp     = 1'b1;
    byp_val = '0;
    if (op_a[1] | op_b[1])      byp_val = 42'd2;
    else if (op_a[0] & op_b[0]) byp_val = 42'd1;
    else if (op_a[0])           byp_val = {op_b[38:2], 3'b000, 2'b00};
    else if (op_b[0])           byp_val = {op_a[38:2], 3'b000, 2'b00};
    else                        byp     = 1'b0;

    v1_d     = adv ? op_valid : v1_q;
    sgn1_d   = adv ? lg[36] : sgn1_q;
    sub1_d   = adv ? (lg[36] ^ sm[36]) : sub1_q;
    scale1_d = adv ? lg[35:27] : scale1_q;
    fl1_d    = adv ? lg[26:0] : fl1_q;
    fs1_d    = adv ? sm[26:0] : fs1_q;
    sh1_d    = adv ? ((diff > 10'd31) ? 5'd31 : diff[4:0]) : sh1_q;
    byp1_d   = adv ? byp : byp1_q;
    bypv1_d  = adv ? byp_val : bypv1_q;
  end

  // S2: align the smaller mantissa and collect the bits shifted out as sticky
  logic [31:0] mant_l, mant_s, mant_sh, mask;
  logic        sticky;

  always_comb begin
    mant_l  = {2'b01, fl1_q, 3'b000};
    mant_s  = {2'b01, fs1_q, 3'b000};
    mant_sh = mant_s >> sh1_q;
    mask    = (32'd1 << sh1_q) - 32'd1;
    sticky  = |(mant_s & mask);

    v2_d      = adv ? v1_q : v2_q;
    sgn2_d    = adv ? sgn1_q : sgn2_q;
    scale2_d  = adv ? scale1_q : scale2_q;
    sum2_d    = adv ? (sub1_q ? mant_l - mant_sh : mant_l + mant_sh) : sum2_q;
    sticky2_d = adv ? sticky : sticky2_q;
    byp2_d    = adv ? byp1_q : byp2_q;
    bypv2_d   = adv ? bypv1_q : bypv2_q;
  end

  // S3: normalize so the leading one lands just above the 30-bit fraction field
  logic [4:0]         p;
  logic [30:0]        norm;
  logic signed [10:0] sc;
  logic [41:0]        res;
  logic               res_tr;

  always_comb begin
    p = '0;
    for (int i = 0; i < 32; i++) begin
      if (sum2_q[i]) p = 5'(i);
    end
    norm   = 31'(sum2_q << (5'd31 - p));
    sc     = $signed({{2{scale2_q[SW-1]}}, scale2_q}) + $signed({6'b0, p}) - 11'sd30;
    res    = {sgn2_q, sc[SW-1:0], norm[30:1], 2'b00};
    res_tr = norm[0] | sticky2_q;
    if (sc > 11'sd240) begin
      res    = {sgn2_q, 9'h0F0, 30'd0, 2'b00};
      res_tr = 1'b1;
    end else if (sc < -11'sd240) begin
      res    = {sgn2_q, 9'h110, 30'd0, 2'b00};
      res_tr = 1'b1;
    end
    if (sum2_q == 32'd0) begin
      res    = 42'd1;
      res_tr = 1'b0;
    end
    if (byp2_q) begin
      res    = bypv2_q;
      res_tr = 1'b0;
    end

    out_valid_d = adv ? v2_q : out_valid_q;
    out_d       = adv ? res : out_q;
    truncated_d = adv ? res_tr : truncated_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q <= 1'b0; sgn1_q <= 1'b0; sub1_q <= 1'b0; scale1_q <= '0;
      fl1_q <= '0; fs1_q <= '0; sh1_q <= '0; byp1_q <= 1'b0; bypv1_q <= '0;
      v2_q <= 1'b0; sgn2_q <= 1'b0; scale2_q <= '0; sum2_q <= '0;
      sticky2_q <= 1'b0; byp2_q <= 1'b0; bypv2_q <= '0;
      out_valid_q <= 1'b0; out_q <= '0; truncated_q <= 1'b0;
    end else begin
      v1_q <= v1_d; sgn1_q <= sgn1_d; sub1_q <= sub1_d; scale1_q <= scale1_d;
      fl1_q <= fl1_d; fs1_q <= fs1_d; sh1_q <= sh1_d; byp1_q <= byp1_d; bypv1_q <= bypv1_d;
      v2_q <= v2_d; sgn2_q <= sgn2_d; scale2_q <= scale2_d; sum2_q <= sum2_d;
      sticky2_q <= sticky2_d; byp2_q <= byp2_d; bypv2_q <= bypv2_d;
      out_valid_q <= out_valid_d; out_q <= out_d; truncated_q <= truncated_d;
    end
  end

endmodule
